lfsr_sequencer: RTL and testbench
=================================

// Module: lfsr_sequencer
// PURPOSE
//  Controller that configures and sequences a WIDTH-bit Fibonacci LFSR engine.
//  On start: captures seed, tap mask and run length; loads the engine; streams
//  cfg_len LFSR states over a valid/ready port with backpressure; pulses done.
//  Sits between a host/config bus and pattern consumers (BIST, scramblers, test gens).
// PARAMETERS
//  WIDTH  4  LFSR state and tap-mask width (>=2)
//  CNT_W  8  width of run-length counter; max run = 2**CNT_W-1 words
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      reset, asynchronous, active-low
//  start     in   1      request a run; sampled only in IDLE
//  cfg_seed  in   WIDTH  initial LFSR state (first word emitted)
//  cfg_taps  in   WIDTH  tap mask; bit i=1 -> state[i] enters XOR feedback
//  cfg_len   in   CNT_W  number of words to emit
//  abort     in   1      terminate current run
//  out_valid out  1      out_data holds a word
//  out_data  out  WIDTH  current LFSR state
//  out_last  out  1      qualifies final word of run (valid only with out_valid)
//  out_ready in   1      consumer accepts word when out_valid&out_ready
//  busy      out  1      high in LOAD/RUN/DONE
//  done      out  1      one-cycle pulse at end of every accepted start
//  err       out  1      sticky: illegal config; cleared by next accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; engine state 0; counter 0.
//  Step rule: fb = ^(state & taps); next = {state[WIDTH-2:0], fb}.
//  FSM (all outputs registered):
//  - IDLE: busy=0. start=1 -> capture cfg_*, clear err, then:
//      cfg_seed==0 or cfg_taps==0 -> err<=1, -> DONE (lock-up guard, no output)
//      cfg_len==0 -> DONE (no output, err stays 0)
//      else -> LOAD.
//  - LOAD: engine loads seed, remaining<=cfg_len; out_valid=0; -> RUN.
//  - RUN: out_valid=1, out_data=engine state, out_last=(remaining==1).
//      Handshake: engine steps, remaining--; if remaining==1 -> DONE.
//      Stall (out_ready=0): out_data/out_last held stable, no step.
//  - DONE: done=1 for exactly one cycle, out_valid=0; -> IDLE.
//  Latency: start sampled at edge T -> LOAD after T, out_valid=1 after T+1;
//   zero-stall run of N words: done high for cycle after last handshake.
//  abort in LOAD/RUN -> DONE next edge; abort with handshake in same cycle:
//   transfer counts (engine steps), then DONE. abort in IDLE/DONE ignored.
//  start while busy ignored (no queuing). cfg_* sampled only on accepted start.
//  Counter never wraps: remaining stops at 1->DONE; no underflow path.
//  Reset mid-run: immediate return to IDLE, out_valid drops asynchronously.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE,LOAD,RUN,DONE, 2-bit),
//   default WIDTH/CNT_W, lfsr next-state function for reuse by benches.
//  Sub-module lfsr_engine (clk, rst, load, step, seed, taps -> state): holds
//   state/taps registers, applies step rule; sequencer owns FSM, counter, port.
// TESTING
//  1 Basic: seed=0001 taps=1100 len=5, ready=1 -> out 0001,0010,0100,1001,0011;
//    out_last on 0011; done 1 cycle after; err=0.
//  2 Max period: seed=0001 taps=1100 len=15 -> 15 distinct nonzero words,
//    none repeat; bench model next value after last equals 0001.
//  3 Backpressure: test 1 with out_ready random 50% -> identical word sequence;
//    out_data stable during every stall cycle.
//  4 Illegal config: seed=0000 (then taps=0000) -> no out_valid, err=1, done pulse;
//    next legal start clears err. len=0 -> done pulse, err=0, no output.
//  5 Abort: len=10, abort after 3rd handshake -> exactly 3 words, done next cycle;
//    start during run ignored (no extra words).
//  6 Async reset: assert rst=0 mid-RUN between edges -> out_valid/busy drop at once;
//    after release, new start runs normally from seed.

Source files
------------

// File: rtl/lfsr_sequencer_pkg.sv
// Shared definitions for the LFSR sequencer slice.
//   state_t     : 2-bit FSM encoding (IDLE, LOAD, RUN, DONE)
//   DEF_WIDTH   : default LFSR state / tap-mask width
//   DEF_CNT_W   : default run-length counter width
//   lfsr_next() : Fibonacci step rule for any width up to 32 bits.
//                 Benches and models can use it without instantiating the engine.
package lfsr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  // The feedback bit is the parity of the state bits selected by the taps.
  // It shifts in at bit 0. Bits at or above w are masked off.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic [31:0] t,
                                            input int unsigned w);
    logic [31:0] mask;
    logic        fb;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    fb   = ^(s & t & mask);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_engine.sv
// Fibonacci LFSR datapath. It holds the working state and the tap mask.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low
//   load  : copy seed and taps into the registers (takes priority over step)
//   step  : advance one LFSR step using the registered taps
//   seed  : initial state presented with load
//   taps  : tap mask presented with load; bit i=1 feeds state[i] into the XOR
//   state : current LFSR state
module lfsr_engine
  import lfsr_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] taps_q;
  logic             fb;

  assign fb = ^(state & taps_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= '0;
      taps_q <= '0;
    end else if (load) begin
      state  <= seed;
      taps_q <= taps;
    end else if (step) begin
      state  <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_sequencer.sv
// Controller for the LFSR engine. A start captures the configuration. The
// engine is then loaded, and cfg_len states stream out over a valid/ready
// port. A done pulse ends every accepted start.
//   clk, rst            : clock (rising edge), async reset (active-low)
//   start               : run request, honoured only in IDLE
//   cfg_seed/taps/len   : run configuration, sampled on an accepted start
//   abort               : cut the current run short (LOAD/RUN only)
//   out_valid/data/last : word stream; out_last marks the final word
//   out_ready           : consumer accepts a word when out_valid & out_ready
//   busy                : high in LOAD/RUN/DONE
//   done                : one-cycle pulse at the end of every accepted start
//   err                 : sticky illegal-config flag, cleared by the next start
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; configuration captured on acceptance
// ST_LOAD | engine loads seed/taps, word counter loads run length
// ST_RUN  | words presented; each handshake steps engine and counter
// ST_DONE | done pulse for one cycle, then back to IDLE
module lfsr_sequencer
  import lfsr_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           fsm;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] taps_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] remaining;
  logic             hs;
  logic             eng_load;
  logic             eng_step;
  logic [WIDTH-1:0] eng_state;

  // out_valid is only ever set in RUN, so a handshake implies RUN.
  assign hs       = out_valid & out_ready;
  assign eng_load = (fsm == ST_LOAD);
  assign eng_step = (fsm == ST_RUN) & hs;

  // The engine register is the data output. It holds during stalls
  // because the engine steps only on a handshake.
  assign out_data = eng_state;

  lfsr_engine #(
    .WIDTH (WIDTH)
  ) u_engine (
    .clk   (clk),
    .rst   (rst),
    .load  (eng_load),
    .step  (eng_step),
    .seed  (seed_q),
    .taps  (taps_q),
    .state (eng_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= ST_IDLE;
      seed_q    <= '0;
      taps_q    <= '0;
      len_q     <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            seed_q <= cfg_seed;
            taps_q <= cfg_taps;
            len_q  <= cfg_len;
            err    <= 1'b0;
            busy   <= 1'b1;
            // An all-zero seed or all-zero taps would lock the LFSR at zero.
            // Such runs are refused with err and emit nothing.
            if (cfg_seed == '0 || cfg_taps == '0) begin
              err  <= 1'b1;
              done <= 1'b1;
              fsm  <= ST_DONE;
            end else if (cfg_len == '0) begin
              done <= 1'b1;
              fsm  <= ST_DONE;
            end else begin
              fsm  <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          remaining <= len_q;
          if (abort) begin
            done <= 1'b1;
            fsm  <= ST_DONE;
          end else begin
            out_valid <= 1'b1;
            out_last  <= (len_q == CNT_W'(1));
            fsm       <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (hs) begin
            remaining <= remaining - CNT_W'(1);
            // The next word is the last when one word remains after this one.
            out_last  <= (remaining == CNT_W'(2));
          end
          // The run ends on the final handshake instead of letting the
          // counter reach zero. The counter therefore cannot underflow.
          if ((hs && remaining == CNT_W'(1)) || abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            fsm       <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy <= 1'b0;
          fsm  <= ST_IDLE;
        end

        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Directed bench for lfsr_sequencer (WIDTH=4, CNT_W=8). Expected words are
// hand-computed for taps=1100 (x^4+x^3+1).
module tb_lfsr_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] cfg_seed;
  logic [3:0] cfg_taps;
  logic [7:0] cfg_len;
  logic       abort;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [3:0] words[$];
  logic       lasts[$];

  // seed=0001 taps=1100, first five words
  logic [3:0] exp5 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};

  lfsr_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_seed  (cfg_seed),
    .cfg_taps  (cfg_taps),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [3:0] s, input logic [3:0] t, input logic [7:0] l);
    cfg_seed = s;
    cfg_taps = t;
    cfg_len  = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Streams words until done. Ready is constant high or random. abort_at > 0
  // asserts abort together with that handshake. start_at > 0 pulses start
  // while word start_at is on the bus. Stall cycles must hold the data.
  task automatic collect(input bit rnd, input int abort_at, input int start_at,
                         output int hs_iter, output int done_iter);
    logic [3:0] hold_d;
    logic       hold_l;
    bit         stall;
    bit         hs;
    words.delete();
    lasts.delete();
    hs_iter   = -1;
    done_iter = -1;
    for (int i = 0; i < 200; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort     = 1'b0;
      start     = 1'b0;
      if (abort_at > 0 && out_valid && words.size() == abort_at - 1) begin
        out_ready = 1'b1;
        abort     = 1'b1;
      end
      if (start_at > 0 && out_valid && words.size() == start_at) start = 1'b1;
      hs     = out_valid && out_ready;
      stall  = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (hs) begin
        words.push_back(out_data);
        lasts.push_back(out_last);
        hs_iter = i;
      end
      tick();
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(hold_d));
        chk("stall_last", 32'(out_last), 32'(hold_l));
      end
      if (done) begin
        done_iter = i;
        break;
      end
    end
    out_ready = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    chk("done_seen", 32'(done_iter >= 0), 1);
  endtask

  initial begin : main
    int         hs_i;
    int         dn_i;
    logic [3:0] m;
    bit         seen[16];

    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_seed = '0; cfg_taps = '0; cfg_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    rst = 1'b1;
    tick();

    // 1 basic
    run_start(4'b0001, 4'b1100, 8'd5);
    chk("t1_load_busy", 32'(busy), 1);
    chk("t1_load_valid", 32'(out_valid), 0);
    collect(1'b0, 0, 0, hs_i, dn_i);
    chk("t1_count", 32'(words.size()), 5);
    for (int i = 0; i < 5 && i < words.size(); i++) begin
      chk("t1_word", 32'(words[i]), 32'(exp5[i]));
      chk("t1_last", 32'(lasts[i]), (i == 4) ? 1 : 0);
    end
    chk("t1_done_lat", 32'(dn_i), 32'(hs_i));
    chk("t1_err", 32'(err), 0);
    chk("t1_done_valid", 32'(out_valid), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // 2 max period
    run_start(4'b0001, 4'b1100, 8'd15);
    collect(1'b0, 0, 0, hs_i, dn_i);
    chk("t2_count", 32'(words.size()), 15);
    m = 4'b0001;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      chk("t2_word", 32'(words[i]), 32'(m));
      chk("t2_nonzero", 32'(words[i] != 4'd0), 1);
      chk("t2_unique", 32'(seen[words[i]]), 0);
      seen[words[i]] = 1'b1;
      m = {m[2:0], m[3] ^ m[2]};
    end
    chk("t2_wrap", 32'(m), 32'(4'b0001));
    chk("t2_last", 32'(lasts[words.size()-1]), 1);
    tick();

    // 3 backpressure
    run_start(4'b0001, 4'b1100, 8'd5);
    collect(1'b1, 0, 0, hs_i, dn_i);
    chk("t3_count", 32'(words.size()), 5);
    for (int i = 0; i < 5 && i < words.size(); i++) begin
      chk("t3_word", 32'(words[i]), 32'(exp5[i]));
      chk("t3_last", 32'(lasts[i]), (i == 4) ? 1 : 0);
    end
    chk("t3_done_lat", 32'(dn_i), 32'(hs_i));
    tick();

    // 4 illegal config: zero seed, then zero taps
    run_start(4'b0000, 4'b1100, 8'd5);
    chk("t4a_done", 32'(done), 1);
    chk("t4a_err", 32'(err), 1);
    chk("t4a_valid", 32'(out_valid), 0);
    chk("t4a_busy", 32'(busy), 1);
    tick();
    chk("t4a_pulse", 32'(done), 0);
    chk("t4a_sticky", 32'(err), 1);
    chk("t4a_valid2", 32'(out_valid), 0);
    run_start(4'b0101, 4'b0000, 8'd5);
    chk("t4b_done", 32'(done), 1);
    chk("t4b_err", 32'(err), 1);
    chk("t4b_valid", 32'(out_valid), 0);
    tick();
    run_start(4'b0101, 4'b1100, 8'd1);
    chk("t4c_err_clr", 32'(err), 0);
    collect(1'b0, 0, 0, hs_i, dn_i);
    chk("t4c_count", 32'(words.size()), 1);
    if (words.size() > 0) begin
      chk("t4c_word", 32'(words[0]), 32'(4'b0101));
      chk("t4c_last", 32'(lasts[0]), 1);
    end
    tick();
    run_start(4'b0101, 4'b1100, 8'd0);
    chk("t4d_done", 32'(done), 1);
    chk("t4d_err", 32'(err), 0);
    chk("t4d_valid", 32'(out_valid), 0);
    tick();
    chk("t4d_valid2", 32'(out_valid), 0);
    chk("t4d_busy", 32'(busy), 0);

    // 5 abort with the third handshake, start during run ignored
    run_start(4'b0001, 4'b1100, 8'd10);
    collect(1'b0, 3, 1, hs_i, dn_i);
    chk("t5_count", 32'(words.size()), 3);
    for (int i = 0; i < 3 && i < words.size(); i++)
      chk("t5_word", 32'(words[i]), 32'(exp5[i]));
    chk("t5_done_lat", 32'(dn_i), 32'(hs_i));
    tick();
    chk("t5_idle_busy", 32'(busy), 0);
    tick();
    chk("t5_no_restart", 32'(out_valid | busy), 0);

    // 6 async reset mid-run
    run_start(4'b0001, 4'b1100, 8'd10);
    out_ready = 1'b1;
    tick();
    tick();
    chk("t6_running", 32'(out_valid), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(out_valid), 0);
    chk("t6_busy_drop", 32'(busy), 0);
    chk("t6_data_clr", 32'(out_data), 0);
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_start(4'b0001, 4'b1100, 8'd5);
    collect(1'b0, 0, 0, hs_i, dn_i);
    chk("t6_count", 32'(words.size()), 5);
    for (int i = 0; i < 5 && i < words.size(); i++)
      chk("t6_word", 32'(words[i]), 32'(exp5[i]));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
